// File: rtl/co2_pkg.sv
// Shared types and constants for the CO2 alarm controller slice.
// Holds the controller state encoding, the default frame width and the
// detector pattern used by reference models.
package co2_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      SHIFT = 3'd2,
      CHECK = 3'd3,
      ALARM = 3'd4
   } state_t;

   localparam int CO2_FRAME_W = 9;

   localparam logic [CO2_FRAME_W-1:0] CO2_PATTERN = 9'b100100100;

endpackage

// File: rtl/co2_alarm_ctrl_shifter.sv
// co2_frame_shifter: parallel-load shift register plus bit counter.
// The register presents its MSB as the next serial bit; shifting and
// counting are separate controls so the controller can pre-fetch the first
// bit while the detector is being cleared.
import co2_pkg::*;

module co2_frame_shifter #(
   parameter int FRAME_W = CO2_FRAME_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               i_load,
   input  logic [FRAME_W-1:0] i_data,
   input  logic               i_shift,
   input  logic               i_count,
   output logic               o_msb,
   output logic               o_last
);

   localparam int BitCntW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

   logic [FRAME_W-1:0] r_shReg;
   logic [BitCntW-1:0] r_bitCnt;

   // Load a new frame or move the next bit up to the MSB position
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_shReg <= '0;
      end else if (i_load) begin
         r_shReg <= i_data;
      end else if (i_shift) begin
         r_shReg <= {r_shReg[FRAME_W-2:0], 1'b0};
      end
   end

   // Count remaining bits; zero marks the final bit of the frame
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_bitCnt <= '0;
      end else if (i_load) begin
         r_bitCnt <= BitCntW'(FRAME_W - 1);
      end else if (i_count && (r_bitCnt != '0)) begin
         r_bitCnt <= r_bitCnt - 1'b1;
      end
   end

   assign o_msb  = r_shReg[FRAME_W-1];
   assign o_last = (r_bitCnt == '0);

endmodule

// File: rtl/co2_alarm_ctrl.sv
// co2_alarm_ctrl: sequencer and alarm controller for the serial CO2
// pattern detector. Accepts frames over valid/ready, clears the detector,
// shifts the frame out MSB-first, samples the hit flag and counts
// consecutive hits, raising a handshaked alarm at the threshold.
// Optional feature: define CO2_CTRL_TIMEOUT_EN to make the alarm exit on
// its own after ALARM_TMO+1 cycles without an acknowledge.
import co2_pkg::*;

module co2_alarm_ctrl #(
   parameter int FRAME_W    = CO2_FRAME_W,
   parameter int HIT_THRESH = 3,
`ifdef CO2_CTRL_TIMEOUT_EN
   parameter int ALARM_TMO  = 15,
`endif
   parameter int CNT_W      = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               i_frame_valid,
   input  logic [FRAME_W-1:0] i_frame_data,
   output logic               o_frame_ready,
   output logic               o_det_x,
   output logic               o_det_rst_n,
   input  logic               i_det_z,
   output logic               o_frame_done,
   output logic [CNT_W-1:0]   o_hit_count,
   output logic               o_alarm,
   input  logic               i_alarm_ack
);

   localparam logic [CNT_W-1:0] HitThreshC = CNT_W'(HIT_THRESH);

`ifdef CO2_CTRL_TIMEOUT_EN
   localparam int TmoW = (ALARM_TMO > 0) ? $clog2(ALARM_TMO + 1) : 1;
`endif

   state_t           r_state;
   logic             r_frameReady;
   logic             r_detX;
   logic             r_detRstN;
   logic             r_frameDone;
   logic [CNT_W-1:0] r_hitCount;
   logic             r_alarm;
`ifdef CO2_CTRL_TIMEOUT_EN
   logic [TmoW-1:0]  r_tmoCnt;
`endif

   logic             w_load;
   logic             w_shift;
   logic             w_count;
   logic             w_msb;
   logic             w_last;
   logic [CNT_W-1:0] w_hitInc;

   assign w_load   = (r_state == IDLE) && i_frame_valid;
   assign w_shift  = (r_state == CLR) || (r_state == SHIFT);
   assign w_count  = (r_state == SHIFT);
   assign w_hitInc = (r_hitCount == '1) ? r_hitCount : r_hitCount + 1'b1;

   co2_frame_shifter #(
      .FRAME_W (FRAME_W)
   ) u_shifter (
      .CLK     (CLK),
      .RST     (RST),
      .i_load  (w_load),
      .i_data  (i_frame_data),
      .i_shift (w_shift),
      .i_count (w_count),
      .o_msb   (w_msb),
      .o_last  (w_last)
   );

   // Frame sequencing FSM; every output is a register updated here so the
   // detector and the front-end only ever see glitch-free levels
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= IDLE;
         r_frameReady <= 1'b1;
         r_detX       <= 1'b0;
         r_detRstN    <= 1'b0;
         r_frameDone  <= 1'b0;
         r_hitCount   <= '0;
         r_alarm      <= 1'b0;
`ifdef CO2_CTRL_TIMEOUT_EN
         r_tmoCnt     <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_detX      <= 1'b0;
               r_frameDone <= 1'b0;
               if (i_frame_valid) begin
                  r_state      <= CLR;
                  r_frameReady <= 1'b0;
                  r_detRstN    <= 1'b0;
               end else begin
                  r_frameReady <= 1'b1;
                  r_detRstN    <= 1'b1;
               end
            end

            CLR: begin
               r_state   <= SHIFT;
               r_detRstN <= 1'b1;
               r_detX    <= w_msb;
            end

            SHIFT: begin
               if (w_last) begin
                  r_state     <= CHECK;
                  r_detX      <= 1'b0;
                  r_frameDone <= 1'b1;
               end else begin
                  r_detX <= w_msb;
               end
            end

            CHECK: begin
               r_frameDone <= 1'b0;
               if (i_det_z) begin
                  r_hitCount <= w_hitInc;
                  if (w_hitInc >= HitThreshC) begin
                     r_state <= ALARM;
                     r_alarm <= 1'b1;
`ifdef CO2_CTRL_TIMEOUT_EN
                     r_tmoCnt <= TmoW'(ALARM_TMO);
`endif
                  end else begin
                     r_state      <= IDLE;
                     r_frameReady <= 1'b1;
                  end
               end else begin
                  r_hitCount   <= '0;
                  r_state      <= IDLE;
                  r_frameReady <= 1'b1;
               end
            end

            ALARM: begin
               if (i_alarm_ack) begin
                  r_hitCount   <= '0;
                  r_alarm      <= 1'b0;
                  r_frameReady <= 1'b1;
                  r_state      <= IDLE;
`ifdef CO2_CTRL_TIMEOUT_EN
               end else if (r_tmoCnt == '0) begin
                  r_hitCount   <= '0;
                  r_alarm      <= 1'b0;
                  r_frameReady <= 1'b1;
                  r_state      <= IDLE;
               end else begin
                  r_tmoCnt <= r_tmoCnt - 1'b1;
`endif
               end
            end

            default: begin
               r_state      <= IDLE;
               r_frameReady <= 1'b1;
               r_detX       <= 1'b0;
               r_detRstN    <= 1'b1;
               r_frameDone  <= 1'b0;
               r_alarm      <= 1'b0;
            end
         endcase
      end
   end

   assign o_frame_ready = r_frameReady;
   assign o_det_x       = r_detX;
   assign o_det_rst_n   = r_detRstN;
   assign o_frame_done  = r_frameDone;
   assign o_hit_count   = r_hitCount;
   assign o_alarm       = r_alarm;

endmodule

// File: tb/tb_co2_alarm_ctrl.sv
// Testbench for co2_alarm_ctrl with a behavioural model of the serial
// pattern detector attached to det_x/det_rst_n/det_z.
// Honours CO2_CTRL_TIMEOUT_EN for the alarm-hold scenario.
module tb_co2_alarm_ctrl;
   import co2_pkg::*;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       frameValid = 1'b0;
   logic [8:0] frameData = '0;
   logic       alarmAck = 1'b0;
   logic       frameReady;
   logic       detX;
   logic       detRstN;
   logic       detZ;
   logic       frameDone;
   logic [3:0] hitCount;
   logic       alarm;
   logic [8:0] detHist;

   int checks = 0;
   int errors = 0;

   co2_alarm_ctrl #(
      .FRAME_W    (9),
      .HIT_THRESH (3),
      .CNT_W      (4)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .i_frame_valid (frameValid),
      .i_frame_data  (frameData),
      .o_frame_ready (frameReady),
      .o_det_x       (detX),
      .o_det_rst_n   (detRstN),
      .i_det_z       (detZ),
      .o_frame_done  (frameDone),
      .o_hit_count   (hitCount),
      .o_alarm       (alarm),
      .i_alarm_ack   (alarmAck)
   );

   always #5 CLK = ~CLK;

   // Detector model: last nine serial bits, cleared by det_rst_n
   always @(posedge CLK or negedge detRstN) begin
      if (!detRstN) detHist <= '0;
      else          detHist <= {detHist[7:0], detX};
   end
   assign detZ = (detHist == CO2_PATTERN);

   task automatic resetDut();
      @(negedge CLK);
      RST = 1'b0;
      frameValid = 1'b0;
      alarmAck = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
   endtask

   // Offer a frame and return at the sample point of the CLR cycle
   task automatic applyStimulus(input logic [8:0] d);
      int waitCnt = 0;
      while (frameReady !== 1'b1 && waitCnt < 40) begin
         @(negedge CLK);
         waitCnt++;
      end
      if (frameReady !== 1'b1) begin
         checks++; errors++;
         $display("[TB] FAIL ready_timeout got %b want 1", frameReady);
      end
      frameValid = 1'b1;
      frameData = d;
      @(negedge CLK);
      frameValid = 1'b0;
      frameData = ~d;
   endtask

   // Whole frame; returns at the first sample point after CHECK
   task automatic runFrame(input logic [8:0] d);
      applyStimulus(d);
      repeat (11) @(negedge CLK);
   endtask

   task automatic test_reset();
      #2 RST = 1'b0;
      repeat (2) @(negedge CLK);
      checks++; if (frameReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %b want 1", frameReady); end
      checks++; if (detX !== 1'b0) begin errors++; $display("[TB] FAIL rst_detx got %b want 0", detX); end
      checks++; if (detRstN !== 1'b0) begin errors++; $display("[TB] FAIL rst_detrst got %b want 0", detRstN); end
      checks++; if (frameDone !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got %b want 0", frameDone); end
      checks++; if (hitCount !== 4'd0) begin errors++; $display("[TB] FAIL rst_hit got %0d want 0", hitCount); end
      checks++; if (alarm !== 1'b0) begin errors++; $display("[TB] FAIL rst_alarm got %b want 0", alarm); end
      RST = 1'b1;
      @(negedge CLK);
      checks++; if (detRstN !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_detrst got %b want 1", detRstN); end
   endtask

   task automatic test_single_frame();
      logic [8:0] pat;
      pat = CO2_PATTERN;
      resetDut();
      applyStimulus(pat);
      checks++; if (detRstN !== 1'b0) begin errors++; $display("[TB] FAIL clr_detrst got %b want 0", detRstN); end
      checks++; if (frameReady !== 1'b0) begin errors++; $display("[TB] FAIL clr_ready got %b want 0", frameReady); end
      for (int i = 0; i < 9; i++) begin
         @(negedge CLK);
         checks++;
         if (detX !== pat[8-i]) begin
            errors++;
            $display("[TB] FAIL shift_bit%0d got %b want %b", i, detX, pat[8-i]);
         end
      end
      @(negedge CLK);
      checks++; if (frameDone !== 1'b1) begin errors++; $display("[TB] FAIL check_done got %b want 1", frameDone); end
      checks++; if (detX !== 1'b0) begin errors++; $display("[TB] FAIL check_detx got %b want 0", detX); end
      @(negedge CLK);
      checks++; if (frameDone !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse got %b want 0", frameDone); end
      checks++; if (hitCount !== 4'd1) begin errors++; $display("[TB] FAIL single_hit got %0d want 1", hitCount); end
      checks++; if (alarm !== 1'b0) begin errors++; $display("[TB] FAIL single_alarm got %b want 0", alarm); end
      checks++; if (frameReady !== 1'b1) begin errors++; $display("[TB] FAIL single_ready got %b want 1", frameReady); end
   endtask

   task automatic test_back_to_back();
      resetDut();
      for (int k = 1; k <= 3; k++) begin
         runFrame(CO2_PATTERN);
         checks++;
         if (hitCount !== 4'(k)) begin
            errors++;
            $display("[TB] FAIL b2b_hit%0d got %0d want %0d", k, hitCount, k);
         end
      end
      checks++; if (alarm !== 1'b1) begin errors++; $display("[TB] FAIL b2b_alarm got %b want 1", alarm); end
      checks++; if (frameReady !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready got %b want 0", frameReady); end
      frameValid = 1'b1;
      frameData = CO2_PATTERN;
      repeat (5) @(negedge CLK);
      checks++; if (alarm !== 1'b1) begin errors++; $display("[TB] FAIL hold_alarm got %b want 1", alarm); end
      checks++; if (frameReady !== 1'b0) begin errors++; $display("[TB] FAIL hold_ready got %b want 0", frameReady); end
      checks++; if (detRstN !== 1'b1) begin errors++; $display("[TB] FAIL hold_ignore_valid got %b want 1", detRstN); end
      checks++; if (hitCount !== 4'd3) begin errors++; $display("[TB] FAIL hold_hit got %0d want 3", hitCount); end
      frameValid = 1'b0;
      alarmAck = 1'b1;
      @(negedge CLK);
      alarmAck = 1'b0;
      checks++; if (alarm !== 1'b0) begin errors++; $display("[TB] FAIL ack_alarm got %b want 0", alarm); end
      checks++; if (hitCount !== 4'd0) begin errors++; $display("[TB] FAIL ack_hit got %0d want 0", hitCount); end
      checks++; if (frameReady !== 1'b1) begin errors++; $display("[TB] FAIL ack_ready got %b want 1", frameReady); end
   endtask

   task automatic test_miss_clears_count();
      logic [8:0] vec [4] = '{9'b100100100, 9'b100100100, 9'b111111111, 9'b100100100};
      logic [3:0] expHit [4] = '{4'd1, 4'd2, 4'd0, 4'd1};
      resetDut();
      for (int k = 0; k < 4; k++) begin
         runFrame(vec[k]);
         checks++;
         if (hitCount !== expHit[k]) begin
            errors++;
            $display("[TB] FAIL miss_hit%0d got %0d want %0d", k, hitCount, expHit[k]);
         end
         checks++;
         if (alarm !== 1'b0) begin
            errors++;
            $display("[TB] FAIL miss_alarm%0d got %b want 0", k, alarm);
         end
      end
   endtask

   task automatic test_isolation();
      resetDut();
      runFrame(CO2_PATTERN);
      checks++; if (hitCount !== 4'd1) begin errors++; $display("[TB] FAIL iso_first got %0d want 1", hitCount); end
      runFrame(9'b000000001);
      checks++; if (hitCount !== 4'd0) begin errors++; $display("[TB] FAIL iso_second got %0d want 0", hitCount); end
   endtask

   task automatic test_reset_mid_frame();
      resetDut();
      runFrame(CO2_PATTERN);
      applyStimulus(CO2_PATTERN);
      repeat (4) @(negedge CLK);
      checks++; if (detX !== 1'b1) begin errors++; $display("[TB] FAIL mid_bit5 got %b want 1", detX); end
      RST = 1'b0;
      #1;
      checks++; if (frameReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %b want 1", frameReady); end
      checks++; if (detX !== 1'b0) begin errors++; $display("[TB] FAIL mid_detx got %b want 0", detX); end
      checks++; if (detRstN !== 1'b0) begin errors++; $display("[TB] FAIL mid_detrst got %b want 0", detRstN); end
      checks++; if (hitCount !== 4'd0) begin errors++; $display("[TB] FAIL mid_hit got %0d want 0", hitCount); end
      checks++; if (alarm !== 1'b0) begin errors++; $display("[TB] FAIL mid_alarm got %b want 0", alarm); end
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      runFrame(CO2_PATTERN);
      checks++; if (hitCount !== 4'd1) begin errors++; $display("[TB] FAIL mid_after_hit got %0d want 1", hitCount); end
      checks++; if (alarm !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_alarm got %b want 0", alarm); end
   endtask

   task automatic test_ack_on_entry();
      resetDut();
      runFrame(CO2_PATTERN);
      runFrame(CO2_PATTERN);
      applyStimulus(CO2_PATTERN);
      repeat (10) @(negedge CLK);
      checks++; if (frameDone !== 1'b1) begin errors++; $display("[TB] FAIL entry_done got %b want 1", frameDone); end
      alarmAck = 1'b1;
      @(negedge CLK);
      checks++; if (alarm !== 1'b1) begin errors++; $display("[TB] FAIL entry_alarm got %b want 1", alarm); end
      @(negedge CLK);
      alarmAck = 1'b0;
      checks++; if (alarm !== 1'b0) begin errors++; $display("[TB] FAIL entry_exit got %b want 0", alarm); end
      checks++; if (frameReady !== 1'b1) begin errors++; $display("[TB] FAIL entry_ready got %b want 1", frameReady); end
      checks++; if (hitCount !== 4'd0) begin errors++; $display("[TB] FAIL entry_hit got %0d want 0", hitCount); end
   endtask

   task automatic test_alarm_hold();
      int highCnt = 0;
      resetDut();
      repeat (3) runFrame(CO2_PATTERN);
      while (alarm === 1'b1 && highCnt < 40) begin
         highCnt++;
         @(negedge CLK);
      end
`ifdef CO2_CTRL_TIMEOUT_EN
      checks++; if (highCnt != 16) begin errors++; $display("[TB] FAIL tmo_cycles got %0d want 16", highCnt); end
      checks++; if (frameReady !== 1'b1) begin errors++; $display("[TB] FAIL tmo_ready got %b want 1", frameReady); end
      checks++; if (hitCount !== 4'd0) begin errors++; $display("[TB] FAIL tmo_hit got %0d want 0", hitCount); end
`else
      checks++; if (highCnt != 40) begin errors++; $display("[TB] FAIL hold_cycles got %0d want 40", highCnt); end
      checks++; if (frameReady !== 1'b0) begin errors++; $display("[TB] FAIL hold40_ready got %b want 0", frameReady); end
      alarmAck = 1'b1;
      @(negedge CLK);
      alarmAck = 1'b0;
      checks++; if (alarm !== 1'b0) begin errors++; $display("[TB] FAIL hold_ack got %b want 0", alarm); end
`endif
   endtask

   // Run every scenario in turn, then report
   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_miss_clears_count();
      test_isolation();
      test_reset_mid_frame();
      test_ack_on_entry();
      test_alarm_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a stuck run
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/co2_alarm_ctrl.md
# co2_alarm_ctrl

Sequencer and alarm controller for the serial CO2 pattern detector. Accepts 9-bit sensor frames over a valid/ready handshake and clears the detector before each frame. Shifts each frame into the detector MSB-first, samples the detector's hit flag after the last bit, and counts consecutive hit frames. Raises a handshaked alarm once the count reaches a threshold. Sits between the sensor front-end and the detector instance.

## Interface
- FRAME_W, 9: bits per frame; matches detector pattern length (pattern 9'b100100100).
- HIT_THRESH, 3: consecutive hit frames required to raise alarm; range 1..2^CNT_W-1.
- CNT_W, 4: width of hit counter.
- ALARM_TMO, 15: alarm auto-exit timeout in cycles; used only with CO2_CTRL_TIMEOUT_EN.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- frame_valid  in  1  frame_data valid; source holds valid and data stable until accepted.
- frame_data  in  FRAME_W  frame; bit FRAME_W-1 shifted first.
- frame_ready  out  1  controller can accept a frame.
- det_x  out  1  serial bit to detector x input.
- det_rst_n  out  1  registered active-low clear to detector RST.
- det_z  in  1  detector hit flag (detector Z).
- frame_done  out  1  one-cycle pulse, frame evaluated.
- hit_count  out  CNT_W  current consecutive-hit count.
- alarm  out  1  alarm active.
- alarm_ack  in  1  alarm acknowledge.

## Operation
- States: IDLE, CLR, SHIFT, CHECK, ALARM; all outputs decoded from registers only.
- IDLE:
  - frame_ready=1.
  - On frame_valid: capture frame_data into shift register, load bit counter with FRAME_W-1, go to CLR.
- CLR: det_rst_n=0 for exactly this one cycle; frame_ready=0; next state SHIFT.
- SHIFT:
  - det_x = shift register MSB.
  - Each cycle: shift left, decrement counter.
  - When counter is 0, the bit on this cycle is the last one; go to CHECK.
  - Exactly FRAME_W SHIFT cycles per frame.
- CHECK: frame_done=1; sample det_z.
  - det_z=1: hit_count increments, saturating at 2^CNT_W-1. If the new count ≥ HIT_THRESH, go to ALARM; else go to IDLE.
  - det_z=0: hit_count cleared to 0; go to IDLE.
- ALARM: alarm=1, frame_ready=0. On alarm_ack (sampled in ALARM): clear hit_count, go to IDLE.
- det_x=0 in all states except SHIFT.
- frame_valid outside IDLE is ignored; data is taken only on the accept cycle.
- Reset values: state IDLE, frame_ready=1, det_x=0, det_rst_n=0, frame_done=0, hit_count=0, alarm=0. det_rst_n rises at the first CLK edge after RST release.
- RST assertion mid-frame or mid-alarm aborts immediately to reset values. The partial frame is discarded and not counted.

## Timing
- Frame accepted at edge T; CLR during cycle T+1; SHIFT during cycles T+2..T+10.
- CHECK during cycle T+11 (detector state reflects all 9 bits).
- frame_ready high again at T+12 if no alarm. Throughput: one frame per 12 cycles.
- alarm rises in cycle T+12 on the threshold frame. It holds at least one cycle; an ack present on entry is honoured at the first ALARM edge.
- Detector start state is always S0: it is cleared in CLR, so earlier traffic cannot cause a false hit.

## Configuration
- CO2_CTRL_TIMEOUT_EN defined:
  - ALARM has a down-counter loaded with ALARM_TMO on entry.
  - On reaching 0 without ack: exit to IDLE after ALARM_TMO+1 cycles in ALARM, with hit_count cleared, same as ack.
  - ack still takes priority at any cycle.
- Not defined: ALARM holds until alarm_ack, indefinitely; no timeout counter is synthesised.

## Structure
- Package co2_pkg holds:
  - state enum (IDLE, CLR, SHIFT, CHECK, ALARM);
  - FRAME_W default;
  - CO2_PATTERN = 9'b100100100 (for bench reference model).
- Sub-module co2_frame_shifter: shift register plus bit counter, with load/shift controls and last-bit flag. It is instantiated once.

## Test plan
- Reset, then frame 9'b100100100 with HIT_THRESH=3 -> det_rst_n low at T+1; det_x = 1,0,0,1,0,0,1,0,0 over T+2..T+10; frame_done at T+11; hit_count=1; alarm stays 0.
- Three back-to-back 9'b100100100 frames -> hit_count 1,2,3; alarm rises cycle after third CHECK; frame_ready=0 until alarm_ack, then hit_count=0.
- Two hits, then 9'b111111111, then one hit -> hit_count 1,2,0,1; alarm never set.
- Frame 9'b000000001 sent after a frame 9'b100100100 is accepted -> det_z=0 in CHECK (clear pulse isolates frames); hit_count=0.
- RST low during SHIFT bit 5 -> all outputs at reset values immediately; next full frame evaluated correctly with hit_count starting at 0.
- With CO2_CTRL_TIMEOUT_EN, ALARM_TMO=15, no ack -> alarm high exactly 16 cycles, then frame_ready=1, hit_count=0.
